// File: rtl/binary_decoder_2to4.sv
// binary_decoder_2to4: 2-to-4 one-hot decoder with enable.
// OUT_REG=1 registers the decode (1-cycle latency); OUT_REG=0 is purely
// combinational. In both modes rst_n low forces the outputs to zero at once.
module binary_decoder_2to4 #(
  parameter int OUT_REG = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] binary_in,
  input  logic       en,
  output logic [3:0] one_hot_out,
  output logic       out_valid
);

  logic [3:0] decoded;

  // One-hot decode of the current inputs; disabled input decodes to all zeros.
  always_comb begin
    decoded = 4'b0000;
    if (en) begin
      case (binary_in)
        2'd0: decoded = 4'b0001;
        2'd1: decoded = 4'b0010;
        2'd2: decoded = 4'b0100;
        2'd3: decoded = 4'b1000;
        default: decoded = 4'b0000;
      endcase
    end
  end

  generate
    if (OUT_REG != 0) begin : g_reg
      logic [3:0] one_hot_q;
      logic       valid_q;

      // Capture decode and enable together so out_valid tracks one_hot_out exactly.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          one_hot_q <= 4'b0000;
          valid_q   <= 1'b0;
        end else begin
          one_hot_q <= decoded;
          valid_q   <= en;
        end
      end

      assign one_hot_out = one_hot_q;
      assign out_valid   = valid_q;
    end else begin : g_comb
      // The clock has no role here; tie it off so it is visibly intentional.
      logic unused_clk;
      assign unused_clk = clk;

      // Zero-latency path; reset still gates the outputs low.
      always_comb begin
        one_hot_out = 4'b0000;
        out_valid   = 1'b0;
        if (rst_n) begin
          one_hot_out = decoded;
          out_valid   = en;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_binary_decoder_2to4.sv
// tb_binary_decoder_2to4: checks the registered and combinational variants
// side by side against an arithmetic reference decode.
module tb_binary_decoder_2to4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [1:0] binary_in;
  logic [3:0] oh_reg, oh_comb;
  logic       v_reg, v_comb;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  binary_decoder_2to4 #(.OUT_REG(1)) dut_reg (
    .clk(clk), .rst_n(rst_n), .binary_in(binary_in), .en(en),
    .one_hot_out(oh_reg), .out_valid(v_reg)
  );

  binary_decoder_2to4 #(.OUT_REG(0)) dut_comb (
    .clk(clk), .rst_n(rst_n), .binary_in(binary_in), .en(en),
    .one_hot_out(oh_comb), .out_valid(v_comb)
  );

  // Reference: bit number binary_in set when enabled, nothing otherwise.
  function automatic logic [3:0] ref_decode(input logic e, input logic [1:0] b);
    logic [3:0] r;
    r = 4'd0;
    if (e) r = 4'(1 << b);
    return r;
  endfunction

  // Present new inputs on the falling edge, then settle briefly.
  task automatic drive(input logic e, input logic [1:0] b);
    @(negedge clk);
    en = e;
    binary_in = b;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en = 1'b1;
    binary_in = 2'd3;
    #2;
    vectors++;
    if (oh_reg !== 4'b0000 || v_reg !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_reg: got oh=%b v=%b, want oh=0000 v=0", oh_reg, v_reg);
    end
    vectors++;
    if (oh_comb !== 4'b0000 || v_comb !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_comb: got oh=%b v=%b, want oh=0000 v=0", oh_comb, v_comb);
    end
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (oh_reg !== 4'b0000 || v_reg !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_hold: got oh=%b v=%b, want oh=0000 v=0", oh_reg, v_reg);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_sweep(input logic e);
    logic [3:0] exp;
    for (int k = 0; k < 4; k++) begin
      drive(e, 2'(k));
      exp = ref_decode(e, 2'(k));
      vectors++;
      if (oh_comb !== exp || v_comb !== e) begin
        miscompares++;
        $display("[TB] FAIL sweep_comb en=%0b in=%0d: got oh=%b v=%b, want oh=%b v=%b",
                 e, k, oh_comb, v_comb, exp, e);
      end
      @(posedge clk);
      #1;
      vectors++;
      if (oh_reg !== exp || v_reg !== e) begin
        miscompares++;
        $display("[TB] FAIL sweep_reg en=%0b in=%0d: got oh=%b v=%b, want oh=%b v=%b",
                 e, k, oh_reg, v_reg, exp, e);
      end
    end
  endtask

  task automatic test_enable_toggle();
    drive(1'b1, 2'd2);
    @(posedge clk);
    #1;
    vectors++;
    if (oh_reg !== 4'b0100 || v_reg !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL toggle_on: got oh=%b v=%b, want oh=0100 v=1", oh_reg, v_reg);
    end
    drive(1'b0, 2'd2);
    @(posedge clk);
    #1;
    vectors++;
    if (oh_reg !== 4'b0000 || v_reg !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL toggle_off: got oh=%b v=%b, want oh=0000 v=0", oh_reg, v_reg);
    end
  endtask

  task automatic test_between_edges();
    drive(1'b1, 2'd3);
    @(posedge clk);
    #2;
    en = 1'b0;
    binary_in = 2'd0;
    #1;
    vectors++;
    if (oh_reg !== 4'b1000 || v_reg !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL midcycle_hold: got oh=%b v=%b, want oh=1000 v=1", oh_reg, v_reg);
    end
    vectors++;
    if (oh_comb !== 4'b0000 || v_comb !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midcycle_comb: got oh=%b v=%b, want oh=0000 v=0", oh_comb, v_comb);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (oh_reg !== 4'b0000 || v_reg !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midcycle_next: got oh=%b v=%b, want oh=0000 v=0", oh_reg, v_reg);
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 2'd3);
    @(posedge clk);
    #1;
    vectors++;
    if (oh_reg !== 4'b1000) begin
      miscompares++;
      $display("[TB] FAIL areset_pre: got oh=%b, want oh=1000", oh_reg);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (oh_reg !== 4'b0000 || v_reg !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL areset_now: got oh=%b v=%b, want oh=0000 v=0", oh_reg, v_reg);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (oh_reg !== 4'b0000 || v_reg !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL areset_hold: got oh=%b v=%b, want oh=0000 v=0", oh_reg, v_reg);
    end
    @(negedge clk);
    en = 1'b1;
    binary_in = 2'd1;
    rst_n = 1'b1;
    #1;
    vectors++;
    if (oh_reg !== 4'b0000 || v_reg !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL areset_stale: got oh=%b v=%b, want oh=0000 v=0", oh_reg, v_reg);
    end
    vectors++;
    if (oh_comb !== 4'b0010 || v_comb !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL areset_comb: got oh=%b v=%b, want oh=0010 v=1", oh_comb, v_comb);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (oh_reg !== 4'b0010 || v_reg !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL areset_first: got oh=%b v=%b, want oh=0010 v=1", oh_reg, v_reg);
    end
  endtask

  task automatic test_back_to_back();
    logic       e;
    logic [1:0] b;
    logic [3:0] exp;
    for (int i = 0; i < 1200; i++) begin
      e = 1'($urandom_range(0, 1));
      b = 2'($urandom_range(0, 3));
      exp = ref_decode(e, b);
      drive(e, b);
      vectors++;
      if (oh_comb !== exp || v_comb !== e) begin
        miscompares++;
        $display("[TB] FAIL random_comb #%0d: got oh=%b v=%b, want oh=%b v=%b",
                 i, oh_comb, v_comb, exp, e);
      end
      @(posedge clk);
      #1;
      vectors++;
      if (oh_reg !== exp || v_reg !== e ||
          $countones(oh_reg) > 1 || $countones(oh_reg) != int'(v_reg)) begin
        miscompares++;
        $display("[TB] FAIL random_reg #%0d: got oh=%b v=%b, want oh=%b v=%b",
                 i, oh_reg, v_reg, exp, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sweep(1'b1);
    test_sweep(1'b0);
    test_enable_toggle();
    test_between_edges();
    test_async_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Guards against a stalled run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
